adc_sar_logic: RTL and testbench
================================

Name: adc_sar_logic

Overview:
- Successive-approximation controller that generates the 12-bit DAC word consumed by the capacitor-array row/column decoder.
- Sequences sampling, binary search and result hand-off for one conversion.
- Takes the comparator decision each bit cycle, builds the trial word MSB-first and publishes the final code with a one-cycle valid pulse.
- Sits between the ADC digital top (start/config/result) and the analog array (decoder input, sample switch, comparator strobe).

Parameters:
- RESOLUTION, 12, DAC word / result width; the bit loop runs RESOLUTION times.
- SAMPLE_CYCLES, 2, cycles the sample switch is held closed (>=1).
- SETTLE_CYCLES, 1, DAC settle cycles before each comparator strobe (>=1).

Ports:
- clk  input  1  block clock; all logic on rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- start_in  input  1  request a conversion; sampled in IDLE or DONE only.
- continuous_in  input  1  1 = restart automatically after DONE.
- comparator_in  input  1  comparator decision; 1 = input >= current DAC word; sampled on the edge closing a COMPARE cycle.
- dac_data_out  output  RESOLUTION  trial word to the row/col decoder; registered.
- sample_out  output  1  sample switch enable; registered.
- comp_strobe_out  output  1  comparator clock/enable; high exactly during COMPARE cycles.
- busy_out  output  1  high in SAMPLE, SETTLE and COMPARE.
- result_out  output  RESOLUTION  last completed code; held until the next completion.
- result_valid_out  output  1  one-cycle pulse when result_out updates.

Behaviour:
- Reset (rst_n=0 at an edge):
  - state=IDLE; dac_data_out=0; result_out=0.
  - sample_out, comp_strobe_out, busy_out, result_valid_out = 0.
  - Reset mid-conversion aborts immediately; no partial result is published.
- States: IDLE, SAMPLE, SETTLE, COMPARE, DONE.
- IDLE:
  - Outputs low; dac_data_out=0.
  - start_in=1 -> SAMPLE; the sample counter loads SAMPLE_CYCLES.
- SAMPLE:
  - sample_out=1, busy_out=1, dac_data_out = midscale (only the MSB set, i.e. 0x800 at 12 bits).
  - Lasts exactly SAMPLE_CYCLES cycles, then -> SETTLE with bit index k=RESOLUTION-1 and the approximation register cleared.
- SETTLE:
  - dac_data_out = approximation bits above k, bit k=1, bits below k=0.
  - Lasts SETTLE_CYCLES cycles, then -> COMPARE.
- COMPARE:
  - One cycle; comp_strobe_out=1 and dac_data_out is unchanged.
  - At the closing edge, the approximation register bit k = comparator_in.
  - If k>0: k decrements, -> SETTLE.
  - If k=0: -> DONE.
- DONE:
  - Lasts one cycle; result_out = final approximation and result_valid_out=1 in that cycle; dac_data_out = final code.
  - Next state: SAMPLE if continuous_in=1 or start_in=1; otherwise IDLE.
- Latency, from the edge sampling start_in to the result_valid_out cycle: 1 + SAMPLE_CYCLES + RESOLUTION*(SETTLE_CYCLES+1) cycles; 27 with the defaults.
- start_in during SAMPLE/SETTLE/COMPARE is ignored (not queued).
- Clearing continuous_in mid-conversion lets the current conversion finish, then the block returns to IDLE unless start_in=1 in DONE.
- dac_data_out changes only on state or bit transitions, never during a COMPARE cycle.
- No arithmetic beyond counters. Counter widths: ceil(log2(max(SAMPLE_CYCLES, SETTLE_CYCLES)+1)) and ceil(log2(RESOLUTION)); no overflow at parameter extremes.

Test Plan:
- Comparator model: comparator_in = (vin_code >= dac_data_out).
  - vin_code=1234, pulse start_in -> result_out=1234.
  - result_valid_out high exactly 27 cycles after the start edge.
  - The dac_data_out sequence begins 0x800, 0x400, 0x600.
  - sample_out high for 2 cycles.
- vin_code=0 -> result 0x000; vin_code=4095 -> result 0xFFF.
  - Exactly 12 comp_strobe_out pulses per conversion.
  - busy_out drops in the DONE cycle.
- Start during busy:
  - vin_code=2048, start, then re-pulse start_in at cycle 10 -> one result (2048), one valid pulse, then IDLE.
- Reset mid-conversion:
  - Assert rst_n=0 at cycle 15 -> next cycle all outputs 0, result_out retains 0, no valid pulse.
  - Fresh start afterwards converts correctly.
- Continuous mode: continuous_in=1, vin_code 100 then 3000 (changed during the first conversion's DONE).
  - Results 100 then 3000.
  - Valid pulses 27 cycles apart.
  - No IDLE cycle between the conversions.
- Parameter sweep: SAMPLE_CYCLES=1, SETTLE_CYCLES=3, vin_code=0xA5A -> result 0xA5A.
  - Latency 1+1+12*4 = 50 cycles.
  - dac_data_out stable across each 3-cycle settle window.

Source files
------------

// File: rtl/adc_sar_logic.sv
// adc_sar_logic: successive-approximation controller producing the DAC trial word and the final conversion code
module adc_sar_logic #(
  parameter int RESOLUTION = 12,
  parameter int SAMPLE_CYCLES = 2,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_in,
  input  logic                  continuous_in,
  input  logic                  comparator_in,
  output logic [RESOLUTION-1:0] dac_data_out,
  output logic                  sample_out,
  output logic                  comp_strobe_out,
  output logic                  busy_out,
  output logic [RESOLUTION-1:0] result_out,
  output logic                  result_valid_out
);
  localparam int MAXC = SAMPLE_CYCLES > SETTLE_CYCLES ? SAMPLE_CYCLES : SETTLE_CYCLES;
  localparam int CW = $clog2(MAXC + 1);
  localparam int KW = RESOLUTION > 1 ? $clog2(RESOLUTION) : 1;
  localparam logic [2:0] IDLE = 3'd0, SAMPLE = 3'd1, SETTLE = 3'd2, COMPARE = 3'd3, DONE = 3'd4;
  localparam logic [RESOLUTION-1:0] ONE = RESOLUTION'(1);
  localparam logic [RESOLUTION-1:0] MID = ONE << (RESOLUTION - 1);
  logic [2:0] state, nxt;
  logic [CW-1:0] cnt, cnt_n;
  logic [KW-1:0] k, k_n;
  logic [RESOLUTION-1:0] sar, sar_n, dac_n;
  always_comb begin
    nxt = state;
    cnt_n = cnt;
    k_n = k;
    sar_n = sar;
    case (state)
      IDLE: if (start_in) begin
        nxt = SAMPLE;
        cnt_n = CW'(SAMPLE_CYCLES);
      end
      SAMPLE: begin
        cnt_n = cnt - 1'b1;
        if (cnt == CW'(1)) begin
          nxt = SETTLE;
          cnt_n = CW'(SETTLE_CYCLES);
          k_n = KW'(RESOLUTION - 1);
          sar_n = '0;
        end
      end
      SETTLE: begin
        cnt_n = cnt - 1'b1;
        if (cnt == CW'(1)) nxt = COMPARE;
      end
      COMPARE: begin
        sar_n[k] = comparator_in;
        if (k == '0) nxt = DONE;
        else begin
          nxt = SETTLE;
          k_n = k - 1'b1;
          cnt_n = CW'(SETTLE_CYCLES);
        end
      end
      DONE: if (continuous_in || start_in) begin
        nxt = SAMPLE;
        cnt_n = CW'(SAMPLE_CYCLES);
      end else nxt = IDLE;
      default: nxt = IDLE;
    endcase
    dac_n = nxt == SAMPLE ? MID :
            (nxt == SETTLE || nxt == COMPARE) ? (sar_n | (ONE << k_n)) :
            nxt == DONE ? sar_n : '0;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      k <= '0;
      sar <= '0;
      dac_data_out <= '0;
      sample_out <= 1'b0;
      comp_strobe_out <= 1'b0;
      busy_out <= 1'b0;
      result_out <= '0;
      result_valid_out <= 1'b0;
    end else begin
      state <= nxt;
      cnt <= cnt_n;
      k <= k_n;
      sar <= sar_n;
      dac_data_out <= dac_n;
      sample_out <= nxt == SAMPLE;
      comp_strobe_out <= nxt == COMPARE;
      busy_out <= nxt == SAMPLE || nxt == SETTLE || nxt == COMPARE;
      result_valid_out <= nxt == DONE;
      if (nxt == DONE) result_out <= sar_n;
    end
  end
endmodule

// File: tb/tb_adc_sar_logic.sv
// tb_adc_sar_logic: directed self-checking bench for adc_sar_logic with an ideal comparator model
module tb_adc_sar_logic;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start_in = 1'b0;
  logic continuous_in = 1'b0;
  logic [11:0] vin = '0;
  logic [11:0] dac, result;
  logic sample, strobe, busy, valid;
  logic start2 = 1'b0;
  logic [11:0] vin2 = '0;
  logic [11:0] dac2, result2;
  logic sample2, strobe2, busy2, valid2;
  int errors = 0;
  int checks = 0;
  always #5 clk = ~clk;
  adc_sar_logic dut (
    .clk(clk), .rst_n(rst_n), .start_in(start_in), .continuous_in(continuous_in),
    .comparator_in(vin >= dac), .dac_data_out(dac), .sample_out(sample),
    .comp_strobe_out(strobe), .busy_out(busy), .result_out(result), .result_valid_out(valid)
  );
  adc_sar_logic #(.RESOLUTION(12), .SAMPLE_CYCLES(1), .SETTLE_CYCLES(3)) dut2 (
    .clk(clk), .rst_n(rst_n), .start_in(start2), .continuous_in(1'b0),
    .comparator_in(vin2 >= dac2), .dac_data_out(dac2), .sample_out(sample2),
    .comp_strobe_out(strobe2), .busy_out(busy2), .result_out(result2), .result_valid_out(valid2)
  );
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic convert(input logic [11:0] v, output int lat, output int strobes, output int samples,
                         output logic [11:0] d0, output logic [11:0] d1, output logic [11:0] d2,
                         output logic busy_done);
    logic [11:0] seq [3];
    logic [11:0] last;
    int n;
    vin = v;
    start_in = 1'b1;
    tick;
    start_in = 1'b0;
    lat = -1;
    strobes = 0;
    samples = 0;
    busy_done = 1'bx;
    n = 0;
    last = 'x;
    seq[0] = 'x;
    seq[1] = 'x;
    seq[2] = 'x;
    for (int c = 1; c <= 200 && lat < 0; c++) begin
      strobes += int'(strobe);
      samples += int'(sample);
      if (dac !== last && n < 3) begin
        seq[n] = dac;
        n++;
      end
      last = dac;
      if (valid === 1'b1) begin
        lat = c;
        busy_done = busy;
      end else tick;
    end
    d0 = seq[0];
    d1 = seq[1];
    d2 = seq[2];
  endtask
  task automatic test_reset;
    rst_n = 1'b0;
    tick;
    tick;
    checks++;
    if ({dac, result} !== 24'h0) begin
      errors++;
      $display("FAIL reset_words dac=%h result=%h required 000 000", dac, result);
    end
    checks++;
    if ({sample, strobe, busy, valid} !== 4'b0) begin
      errors++;
      $display("FAIL reset_flags sample/strobe/busy/valid=%b required 0000", {sample, strobe, busy, valid});
    end
    rst_n = 1'b1;
    tick;
  endtask
  task automatic test_basic;
    int lat, st, sm;
    logic [11:0] d0, d1, d2;
    logic bd;
    convert(12'd1234, lat, st, sm, d0, d1, d2, bd);
    checks++;
    if (result !== 12'd1234) begin
      errors++;
      $display("FAIL basic_result got %0d required 1234", result);
    end
    checks++;
    if (lat != 27) begin
      errors++;
      $display("FAIL basic_latency got %0d required 27", lat);
    end
    checks++;
    if ({d0, d1, d2} !== {12'h800, 12'h400, 12'h600}) begin
      errors++;
      $display("FAIL basic_dac_seq got %h %h %h required 800 400 600", d0, d1, d2);
    end
    checks++;
    if (sm != 2) begin
      errors++;
      $display("FAIL basic_sample_cycles got %0d required 2", sm);
    end
    tick;
    checks++;
    if ({valid, busy, dac} !== {1'b0, 1'b0, 12'h000} || result !== 12'd1234) begin
      errors++;
      $display("FAIL basic_after_done valid=%b busy=%b dac=%h result=%0d required 0 0 000 1234", valid, busy, dac, result);
    end
  endtask
  task automatic test_extremes;
    int lat, st, sm;
    logic [11:0] d0, d1, d2;
    logic bd;
    convert(12'd0, lat, st, sm, d0, d1, d2, bd);
    checks++;
    if (result !== 12'h000 || st != 12 || bd !== 1'b0) begin
      errors++;
      $display("FAIL zero_code result=%h strobes=%0d busy_in_done=%b required 000 12 0", result, st, bd);
    end
    tick;
    convert(12'd4095, lat, st, sm, d0, d1, d2, bd);
    checks++;
    if (result !== 12'hFFF || st != 12 || bd !== 1'b0) begin
      errors++;
      $display("FAIL full_code result=%h strobes=%0d busy_in_done=%b required fff 12 0", result, st, bd);
    end
    tick;
  endtask
  task automatic test_start_during_busy;
    int pulses = 0;
    int first = -1;
    logic [11:0] res = 'x;
    vin = 12'd2048;
    start_in = 1'b1;
    tick;
    start_in = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      start_in = c == 10;
      if (valid === 1'b1) begin
        pulses++;
        res = result;
        if (first < 0) first = c;
      end
      tick;
    end
    start_in = 1'b0;
    checks++;
    if (pulses != 1 || res !== 12'd2048 || first != 27) begin
      errors++;
      $display("FAIL busy_start pulses=%0d result=%0d valid_cycle=%0d required 1 2048 27", pulses, res, first);
    end
    checks++;
    if (busy !== 1'b0 || dac !== 12'h000) begin
      errors++;
      $display("FAIL busy_start_idle busy=%b dac=%h required 0 000", busy, dac);
    end
  endtask
  task automatic test_reset_mid;
    int pulses = 0;
    int lat, st, sm;
    logic [11:0] d0, d1, d2;
    logic bd;
    vin = 12'd1000;
    start_in = 1'b1;
    tick;
    start_in = 1'b0;
    for (int c = 1; c < 15; c++) tick;
    rst_n = 1'b0;
    tick;
    checks++;
    if ({dac, result, sample, strobe, busy, valid} !== 28'h0) begin
      errors++;
      $display("FAIL mid_reset dac=%h result=%h s/c/b/v=%b required all zero", dac, result, {sample, strobe, busy, valid});
    end
    rst_n = 1'b1;
    for (int c = 0; c < 40; c++) begin
      tick;
      pulses += int'(valid);
    end
    checks++;
    if (pulses != 0 || result !== 12'h000) begin
      errors++;
      $display("FAIL mid_reset_no_result pulses=%0d result=%h required 0 000", pulses, result);
    end
    convert(12'd1000, lat, st, sm, d0, d1, d2, bd);
    checks++;
    if (result !== 12'd1000 || lat != 27) begin
      errors++;
      $display("FAIL post_reset_conv result=%0d latency=%0d required 1000 27", result, lat);
    end
    tick;
  endtask
  task automatic test_continuous;
    int n = 0;
    int t0 = -1;
    int t1 = -1;
    int idle_gap = 0;
    logic [11:0] r0 = 'x;
    logic [11:0] r1 = 'x;
    continuous_in = 1'b1;
    vin = 12'd100;
    start_in = 1'b1;
    tick;
    start_in = 1'b0;
    for (int c = 1; c <= 120 && n < 2; c++) begin
      if (valid === 1'b1) begin
        if (n == 0) begin
          t0 = c;
          r0 = result;
          vin = 12'd3000;
        end else begin
          t1 = c;
          r1 = result;
          continuous_in = 1'b0;
        end
        n++;
      end else if (n == 1 && busy !== 1'b1) idle_gap++;
      tick;
    end
    continuous_in = 1'b0;
    checks++;
    if (r0 !== 12'd100 || r1 !== 12'd3000) begin
      errors++;
      $display("FAIL cont_results got %0d %0d required 100 3000", r0, r1);
    end
    checks++;
    if (t0 != 27 || t1 - t0 != 27 || idle_gap != 0) begin
      errors++;
      $display("FAIL cont_timing first=%0d spacing=%0d idle_gap=%0d required 27 27 0", t0, t1 - t0, idle_gap);
    end
    checks++;
    if (busy !== 1'b0 || valid !== 1'b0) begin
      errors++;
      $display("FAIL cont_stop busy=%b valid=%b required 0 0", busy, valid);
    end
  endtask
  task automatic test_param_sweep;
    int lat = -1;
    int run = 0;
    int bad = 0;
    logic [11:0] wdac = '0;
    vin2 = 12'hA5A;
    start2 = 1'b1;
    tick;
    start2 = 1'b0;
    for (int c = 1; c <= 200 && lat < 0; c++) begin
      if (busy2 && !sample2 && !strobe2) begin
        if (run == 0) wdac = dac2;
        else if (dac2 !== wdac) bad++;
        run++;
      end else if (strobe2) begin
        if (run != 3 || dac2 !== wdac) bad++;
        run = 0;
      end
      if (valid2 === 1'b1) lat = c;
      else tick;
    end
    checks++;
    if (result2 !== 12'hA5A || lat != 50) begin
      errors++;
      $display("FAIL sweep_conv result=%h latency=%0d required a5a 50", result2, lat);
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL sweep_settle_window violations=%0d required 0", bad);
    end
    tick;
  endtask
  initial begin
    test_reset;
    test_basic;
    test_extremes;
    test_start_during_busy;
    test_reset_mid;
    test_continuous;
    test_param_sweep;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
